// File: rtl/sram_arbiter_l1_if.sv
// Requester handshake/payload/response and SRAM wrapper signals for sram_arbiter_l1.
// The arbiter takes the slave view; requesters and the wrapper model take the master view.
interface sram_arbiter_l1_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MASK_W = 4
);
    logic              r0_req;
    logic              r0_ready;
    logic              r0_wr;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic [MASK_W-1:0] r0_wmask;
    logic              r0_resp_valid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;

    logic              r1_req;
    logic              r1_ready;
    logic              r1_wr;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic [MASK_W-1:0] r1_wmask;
    logic              r1_resp_valid;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;

    logic              mem_csb;
    logic              mem_web;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_ready;

    modport slave (
        input  r0_req, r0_wr, r0_addr, r0_wdata, r0_wmask,
        input  r1_req, r1_wr, r1_addr, r1_wdata, r1_wmask,
        input  mem_data_out, mem_data_ready,
        output r0_ready, r0_resp_valid, r0_rdata, r0_err,
        output r1_ready, r1_resp_valid, r1_rdata, r1_err,
        output mem_csb, mem_web, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output r0_req, r0_wr, r0_addr, r0_wdata, r0_wmask,
        output r1_req, r1_wr, r1_addr, r1_wdata, r1_wmask,
        output mem_data_out, mem_data_ready,
        input  r0_ready, r0_resp_valid, r0_rdata, r0_err,
        input  r1_ready, r1_resp_valid, r1_rdata, r1_err,
        input  mem_csb, mem_web, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/sram_arbiter_l1.sv
// Two-requester round-robin arbiter in front of a single-port SRAM wrapper: timed write
// strobes, read-ready wait with timeout, one-cycle response, then an idle gap.
module sram_arbiter_l1 #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MASK_W      = 4,
    parameter int unsigned INIT_CYCLES = 16,
    parameter int unsigned WR_CYCLES   = 8,
    parameter int unsigned RD_TIMEOUT  = 32,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input logic              clk,
    input logic              rst_n,
    sram_arbiter_l1_if.slave bus
);
    localparam int unsigned MaxAb  = (INIT_CYCLES > RD_TIMEOUT) ? INIT_CYCLES : RD_TIMEOUT;
    localparam int unsigned MaxCd  = (WR_CYCLES > GAP_CYCLES) ? WR_CYCLES : GAP_CYCLES;
    localparam int unsigned MaxCyc = (MaxAb > MaxCd) ? MaxAb : MaxCd;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] InitLast = CntW'(INIT_CYCLES - 1);
    localparam logic [CntW-1:0] WrLast   = CntW'(WR_CYCLES - 1);
    localparam logic [CntW-1:0] RdLast   = CntW'(RD_TIMEOUT - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StInit, StIdle, StRdWait, StWrHold, StResp, StGap} state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     last_q, last_d;
    logic                     owner_q, owner_d;
    logic                     csb_q, csb_d;
    logic                     web_q, web_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [MASK_W-1:0]        wmask_q, wmask_d;
    logic [1:0]               resp_valid_q, resp_valid_d;
    logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]               err_q, err_d;

    logic              gnt0, gnt1;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;

    // last_q names the requester served most recently; the other one wins a tie.
    assign gnt0 = (state_q == StIdle) && bus.r0_req && (!bus.r1_req || last_q);
    assign gnt1 = (state_q == StIdle) && bus.r1_req && (!bus.r0_req || !last_q);

    assign sel_wr    = gnt1 ? bus.r1_wr    : bus.r0_wr;
    assign sel_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
    assign sel_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;
    assign sel_wmask = gnt1 ? bus.r1_wmask : bus.r0_wmask;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CntW'(1);
        last_d       = last_q;
        owner_d      = owner_q;
        csb_d        = csb_q;
        web_d        = web_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        resp_valid_d = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;

        unique case (state_q)
            StInit: begin
                if (cnt_q == InitLast) state_d = StIdle;
            end
            StIdle: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    last_d  = gnt1;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wmask_d = sel_wmask;
                    csb_d   = 1'b0;
                    web_d   = !sel_wr;
                    state_d = sel_wr ? StWrHold : StRdWait;
                end
            end
            StRdWait: begin
                if (bus.mem_data_ready) begin
                    rdata_d[owner_q] = bus.mem_data_out;
                    err_d[owner_q]   = 1'b0;
                    state_d          = StResp;
                end else if (cnt_q == RdLast) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = StResp;
                end
            end
            StWrHold: begin
                if (cnt_q == WrLast) begin
                    err_d[owner_q] = 1'b0;
                    state_d        = StResp;
                end
            end
            StResp: begin
                state_d = StGap;
            end
            StGap: begin
                if (cnt_q == GapLast) state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Release the wrapper as the response is registered so the gap starts with csb high.
        if (state_d == StResp && state_q != StResp) begin
            resp_valid_d[owner_q] = 1'b1;
            csb_d                 = 1'b1;
            web_d                 = 1'b1;
        end

        if (state_d != state_q || state_q == StIdle) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            csb_q        <= csb_d;
            web_q        <= web_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.r0_ready      = gnt0;
    assign bus.r1_ready      = gnt1;
    assign bus.r0_resp_valid = resp_valid_q[0];
    assign bus.r1_resp_valid = resp_valid_q[1];
    assign bus.r0_rdata      = rdata_q[0];
    assign bus.r1_rdata      = rdata_q[1];
    assign bus.r0_err        = err_q[0];
    assign bus.r1_err        = err_q[1];
    assign bus.mem_csb       = csb_q;
    assign bus.mem_web       = web_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
endmodule

// File: tb/tb_sram_arbiter_l1.sv
// Directed bench for sram_arbiter_l1: a transaction-timeline model checked every cycle,
// plus literal latency/ordering/data expectations for each scenario.
module tb_sram_arbiter_l1;
    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MASK_W      = 4;
    localparam int unsigned INIT_CYCLES = 16;
    localparam int unsigned WR_CYCLES   = 8;
    localparam int unsigned RD_TIMEOUT  = 32;
    localparam int unsigned GAP_CYCLES  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_l1_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    sram_arbiter_l1 #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_CYCLES(INIT_CYCLES),
        .WR_CYCLES(WR_CYCLES), .RD_TIMEOUT(RD_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // cycle number since reset release: cycle 0 is the one in which rst_n rises
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- timeline model ----------------
    bit                m_act, m_ended, m_own, m_wr, m_last, m_new_err;
    int                m_a, m_end, m_idle_from;
    bit                m_idle, g0, g1, low;
    logic [1:0]        rv_e;
    logic [DATA_W-1:0] m_new_rd;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [MASK_W-1:0] e_wmask;
    logic [DATA_W-1:0] e_rdata [2];
    logic [1:0]        e_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 1'b0; m_ended = 1'b0; m_last = 1'b1; m_idle_from = INIT_CYCLES;
            e_addr = '0; e_wdata = '0; e_wmask = '0;
            e_rdata[0] = '0; e_rdata[1] = '0; e_err = 2'b00;
            chk("rst mem_csb", bus.mem_csb, 1'b1);
            chk("rst mem_web", bus.mem_web, 1'b1);
            chk("rst ready", {bus.r1_ready, bus.r0_ready}, 2'b00);
            chk("rst resp_valid", {bus.r1_resp_valid, bus.r0_resp_valid}, 2'b00);
            chk("rst err", {bus.r1_err, bus.r0_err}, 2'b00);
            chk("rst rdata", {bus.r1_rdata, bus.r0_rdata}, 64'h0);
            chk("rst mem_addr", bus.mem_addr, '0);
        end else begin
            m_idle = !m_act && (cyc >= m_idle_from);
            g0 = m_idle && bus.r0_req && (!bus.r1_req || m_last);
            g1 = m_idle && bus.r1_req && (!bus.r0_req || !m_last);
            low = m_act && (cyc > m_a) && (!m_ended || cyc <= m_end);
            rv_e = 2'b00;
            if (m_act && m_ended && cyc == m_end + 1) rv_e[m_own] = 1'b1;

            chk("r0_ready", bus.r0_ready, g0);
            chk("r1_ready", bus.r1_ready, g1);
            chk("mem_csb", bus.mem_csb, !low);
            chk("mem_web", bus.mem_web, !(low && m_wr));
            chk("r0_resp_valid", bus.r0_resp_valid, rv_e[0]);
            chk("r1_resp_valid", bus.r1_resp_valid, rv_e[1]);
            chk("r0_rdata", bus.r0_rdata, e_rdata[0]);
            chk("r1_rdata", bus.r1_rdata, e_rdata[1]);
            chk("r0_err", bus.r0_err, e_err[0]);
            chk("r1_err", bus.r1_err, e_err[1]);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wdata);
            chk("mem_wmask", bus.mem_wmask, e_wmask);

            if (g0 || g1) begin
                m_act = 1'b1; m_a = cyc; m_own = g1; m_last = g1;
                m_wr    = g1 ? bus.r1_wr : bus.r0_wr;
                e_addr  = g1 ? bus.r1_addr : bus.r0_addr;
                e_wdata = g1 ? bus.r1_wdata : bus.r0_wdata;
                e_wmask = g1 ? bus.r1_wmask : bus.r0_wmask;
                m_ended = m_wr; m_end = cyc + WR_CYCLES;
                m_new_rd = e_rdata[g1]; m_new_err = 1'b0;
            end else if (m_act && !m_ended && cyc > m_a) begin
                if (bus.mem_data_ready) begin
                    m_ended = 1'b1; m_end = cyc; m_new_rd = bus.mem_data_out; m_new_err = 1'b0;
                end else if (cyc - m_a == RD_TIMEOUT) begin
                    m_ended = 1'b1; m_end = cyc; m_new_rd = e_rdata[m_own]; m_new_err = 1'b1;
                end
            end
            if (m_act && m_ended && cyc == m_end) begin
                e_rdata[m_own] = m_new_rd;
                e_err[m_own]   = m_new_err;
            end else if (m_act && m_ended && cyc == m_end + 1) begin
                m_act = 1'b0;
                m_idle_from = cyc + 1 + GAP_CYCLES;
            end
        end
    end

    // ---------------- event counters ----------------
    int r1_accs = 0;
    int rv1_cnt = 0;
    int wr_low_cnt = 0;
    always @(negedge clk) begin
        if (bus.r1_req && bus.r1_ready) r1_accs++;
        if (bus.r1_resp_valid) rv1_cnt++;
        if (!bus.mem_csb && !bus.mem_web) wr_low_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_req(input bit id, input bit req, input bit wr,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                             input logic [MASK_W-1:0] wm);
        if (!id) begin
            bus.r0_req = req; bus.r0_wr = wr; bus.r0_addr = addr;
            bus.r0_wdata = wd; bus.r0_wmask = wm;
        end else begin
            bus.r1_req = req; bus.r1_wr = wr; bus.r1_addr = addr;
            bus.r1_wdata = wd; bus.r1_wmask = wm;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    // rd_delay=k pulses mem_data_ready in cycle accept+k; 0 never pulses it.
    task automatic txn(input bit id, input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] wm,
                       input int rd_delay, input logic [DATA_W-1:0] rd_data,
                       output int acc_c, output int resp_c);
        int n;
        drive_req(id, 1'b1, wr, addr, wd, wm);
        acc_c = -1; resp_c = -1; n = 0;
        while (acc_c < 0 && n < 100) begin
            @(negedge clk);
            if (id ? bus.r1_ready : bus.r0_ready) acc_c = cyc;
            @(posedge clk); #1;
            n++;
        end
        // scrambled payload after accept must not matter
        drive_req(id, 1'b0, !wr, ~addr, ~wd, ~wm);
        if (acc_c < 0) chk("accept timeout", 1'b0, 1'b1);
        if (acc_c >= 0 && !wr && rd_delay > 0) begin
            repeat (rd_delay - 1) @(posedge clk);
            #1;
            bus.mem_data_ready = 1'b1; bus.mem_data_out = rd_data;
            @(posedge clk); #1;
            bus.mem_data_ready = 1'b0; bus.mem_data_out = 32'hBAD0_BAD0;
        end
        n = 0;
        while (acc_c >= 0 && resp_c < 0 && n < 100) begin
            @(negedge clk);
            if (id ? bus.r1_resp_valid : bus.r0_resp_valid) resp_c = cyc;
            n++;
        end
        if (acc_c >= 0 && resp_c < 0) chk("response timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    int acc, rsp, nacc, gap_hi, n, accs_before, rv1_before;
    bit both;
    logic [3:0] ord;

    initial begin
        drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        bus.mem_data_ready = 1'b0;
        bus.mem_data_out = 32'hBAD0_BAD0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // INIT holds off a request made at cycle 3 until cycle 16
        repeat (3) @(posedge clk);
        #1;
        txn(1'b0, 1'b0, 9'h005, 32'h0, 4'h0, 3, 32'h0000_00A5, acc, rsp);
        chk("init first accept cycle", acc, 16);
        chk("read latency k=3", rsp - acc, 4);
        chk("r0 read data", bus.r0_rdata, 32'h0000_00A5);
        chk("r0 read err", bus.r0_err, 1'b0);

        // write holds strobes WR_CYCLES cycles, response at accept+9
        wr_low_cnt = 0;
        txn(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, acc, rsp);
        chk("write latency", rsp - acc, 9);
        chk("write strobe cycles", wr_low_cnt, 8);
        chk("r0 write err", bus.r0_err, 1'b0);

        // slow read answered after 20 cycles, then gap with csb high
        txn(1'b1, 1'b0, 9'h010, 32'h0, 4'h0, 20, 32'hDEAD_BEEF, acc, rsp);
        chk("read latency k=20", rsp - acc, 21);
        chk("r1 read data", bus.r1_rdata, 32'hDEAD_BEEF);
        chk("r1 read err", bus.r1_err, 1'b0);
        gap_hi = 0;
        repeat (GAP_CYCLES) begin
            @(negedge clk);
            if (bus.mem_csb && bus.mem_web) gap_hi++;
        end
        chk("gap cycles csb high", gap_hi, GAP_CYCLES);

        // both requesting continuously: alternate grants starting with r0
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b1, 9'h020, 32'h1111_1111, 4'h3);
        drive_req(1'b1, 1'b1, 1'b1, 9'h030, 32'h2222_2222, 4'hC);
        nacc = 0; n = 0; both = 1'b0; ord = '0;
        while (nacc < 4 && n < 200) begin
            @(negedge clk);
            if (bus.r0_ready && bus.r1_ready) both = 1'b1;
            if (bus.r0_ready) begin ord[nacc] = 1'b0; nacc++; end
            else if (bus.r1_ready) begin ord[nacc] = 1'b1; nacc++; end
            @(posedge clk); #1;
            n++;
        end
        drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        chk("rr accept count", nacc, 4);
        chk("rr dual grant", both, 1'b0);
        chk("rr order r0,r1,r0,r1", ord, 4'b1010);

        // request withdrawn while busy is dropped
        accs_before = r1_accs;
        drive_req(1'b1, 1'b1, 1'b0, 9'h0AA, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (20) @(posedge clk);
        #1;
        chk("dropped request not accepted", r1_accs, accs_before);

        // stray ready while idle is ignored
        bus.mem_data_ready = 1'b1; bus.mem_data_out = 32'hFFFF_0000;
        @(posedge clk); #1;
        bus.mem_data_ready = 1'b0; bus.mem_data_out = 32'hBAD0_BAD0;

        // read timeout
        txn(1'b0, 1'b0, 9'h1FF, 32'h0, 4'h0, 0, 32'h0, acc, rsp);
        chk("timeout latency", rsp - acc, 33);
        chk("timeout err", bus.r0_err, 1'b1);
        chk("timeout rdata kept", bus.r0_rdata, 32'h0000_00A5);

        // minimum read latency
        txn(1'b1, 1'b0, 9'h002, 32'h0, 4'h0, 1, 32'h5A5A_5A5A, acc, rsp);
        chk("read latency k=1", rsp - acc, 2);
        chk("r1 fast read data", bus.r1_rdata, 32'h5A5A_5A5A);

        txn(1'b0, 1'b1, 9'h003, 32'hCAFE_F00D, 4'h5, 0, 32'h0, acc, rsp);
        chk("write clears err", bus.r0_err, 1'b0);

        // reset during write hold aborts with no response
        rv1_before = rv1_cnt;
        drive_req(1'b1, 1'b1, 1'b1, 9'h044, 32'h4444_4444, 4'hF);
        n = 0;
        while (!bus.r1_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("in write hold csb", bus.mem_csb, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async reset mem_csb", bus.mem_csb, 1'b1);
        chk("async reset mem_web", bus.mem_web, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        txn(1'b0, 1'b0, 9'h006, 32'h0, 4'h0, 2, 32'h0000_0077, acc, rsp);
        chk("init repeats after reset", acc, 16);
        chk("aborted write no response", rv1_cnt, rv1_before);
        chk("post-reset r1 rdata", bus.r1_rdata, 32'h0);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
